// File: rtl/ann_coef_loader.sv
// Responder for the ANN coefficient-request handshake: fetches a batch of
// coefficient words from weight memory, one outstanding read at a time, into the node register file.
module ann_coef_loader #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              request_coef,
  input  logic [CNT_W-1:0]  max_input,
  input  logic              done_processing,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              coef_wen,
  output logic [CNT_W-1:0]  coef_waddr,
  output logic [DATA_W-1:0] coef_wdata,
  output logic              coef_loaded,
  output logic              busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A rewind in the same IDLE cycle as a request lands first, so that load starts at BASE_ADDR.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (done_processing) begin
          ptr_d = BASE_ADDR;
        end
        if (request_coef) begin
          count_d = max_input;
          idx_d   = '0;
          state_d = (max_input != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (mem_valid) begin
          data_d  = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d = ptr_q + ADDR_ONE;
        if (idx_q == count_q - CNT_ONE) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Write index and data are gated so the register-file bus idles at zero outside WRITE.
  assign mem_read    = (state_q == ISSUE);
  assign mem_addr    = ptr_q;
  assign coef_wen    = (state_q == WRITE);
  assign coef_waddr  = coef_wen ? idx_q : '0;
  assign coef_wdata  = coef_wen ? data_q : '0;
  assign coef_loaded = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ann_coef_loader.sv
// Scoreboard bench for ann_coef_loader: a 16-bit-address instance for the load,
// pointer and latency cases, and a 4-bit-address instance for wrap and mid-batch reset.
module tb_ann_coef_loader;

  typedef struct {
    logic [6:0] idx;
    logic [7:0] data;
  } wr_t;

  logic        clk;
  logic        nRst;
  logic        requestCoef, requestCoefB;
  logic [6:0]  maxInput, maxInputB;
  logic        doneProcessing, doneProcessingB;
  logic [7:0]  memRdata;
  logic        memValid;

  logic        memRead, memReadB;
  logic [15:0] memAddr;
  logic [3:0]  memAddrB;
  logic        coefWen, coefWenB;
  logic [6:0]  coefWaddr, coefWaddrB;
  logic [7:0]  coefWdata, coefWdataB;
  logic        coefLoaded, coefLoadedB;
  logic        busy, busyB;

  bit          useB;
  logic        selRead, selWen, selLoaded, selBusy;
  logic [15:0] selAddr;
  logic [6:0]  selWaddr;
  logic [7:0]  selWdata;

  int          compCount = 0;
  int          failCount = 0;
  int          cycleCnt = 0;
  int          reqCycle = 0;
  int          expLatency = 0;
  int          curLat = 1;
  int          ptrA = 0;
  int          ptrB = 0;
  int          wrCount = 0;
  bit          loadArmed = 0;
  bit          loadSeen = 0;
  bit          pending = 0;
  int          waitCnt = 0;
  logic [15:0] pendAddr = '0;

  logic [15:0] expAddrQ[$];
  wr_t         expWrQ[$];
  int          latQ[$];

  ann_coef_loader #(.DATA_W(8), .ADDR_W(16), .BASE_ADDR(16'h0000), .CNT_W(7)) u_dut (
    .clk(clk), .n_rst(nRst), .request_coef(requestCoef), .max_input(maxInput),
    .done_processing(doneProcessing), .mem_read(memRead), .mem_addr(memAddr),
    .mem_rdata(memRdata), .mem_valid(memValid), .coef_wen(coefWen),
    .coef_waddr(coefWaddr), .coef_wdata(coefWdata), .coef_loaded(coefLoaded), .busy(busy)
  );

  ann_coef_loader #(.DATA_W(8), .ADDR_W(4), .BASE_ADDR(4'h0), .CNT_W(7)) u_dutB (
    .clk(clk), .n_rst(nRst), .request_coef(requestCoefB), .max_input(maxInputB),
    .done_processing(doneProcessingB), .mem_read(memReadB), .mem_addr(memAddrB),
    .mem_rdata(memRdata), .mem_valid(memValid), .coef_wen(coefWenB),
    .coef_waddr(coefWaddrB), .coef_wdata(coefWdataB), .coef_loaded(coefLoadedB), .busy(busyB)
  );

  assign selRead   = useB ? memReadB    : memRead;
  assign selAddr   = useB ? {12'd0, memAddrB} : memAddr;
  assign selWen    = useB ? coefWenB    : coefWen;
  assign selWaddr  = useB ? coefWaddrB  : coefWaddr;
  assign selWdata  = useB ? coefWdataB  : coefWdata;
  assign selLoaded = useB ? coefLoadedB : coefLoaded;
  assign selBusy   = useB ? busyB       : busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor and memory model share one block so the read check sees the pending state in order.
  always @(negedge clk) begin
    if (selRead) begin
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpectedRead", 32'(selRead), 32'd0);
      end else begin
        checkOutput("readAddr", 32'(selAddr), 32'(expAddrQ.pop_front()));
      end
    end
    if (selWen) begin
      wrCount++;
      if (expWrQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'(selWen), 32'd0);
      end else begin
        wr_t e;
        e = expWrQ.pop_front();
        checkOutput("writeIdx", 32'(selWaddr), 32'(e.idx));
        checkOutput("writeData", 32'(selWdata), 32'(e.data));
      end
    end
    if (selLoaded) begin
      if (loadArmed) begin
        checkOutput("loadLatency", 32'(cycleCnt - reqCycle + 1), 32'(expLatency));
        loadArmed = 0;
        loadSeen  = 1;
      end else begin
        checkOutput("spuriousLoaded", 32'(selLoaded), 32'd0);
      end
    end

    memValid = 1'b0;
    if (pending) begin
      waitCnt--;
      if (waitCnt == 0) begin
        memValid = 1'b1;
        memRdata = pendAddr[7:0] + 8'd3;
        pending  = 0;
      end
    end
    if (selRead) begin
      checkOutput("readWhilePending", 32'(pending), 32'd0);
      pending  = 1;
      pendAddr = selAddr;
      waitCnt  = (latQ.size() != 0) ? latQ.pop_front() : curLat;
    end
  end

  // Queues the expected reads/writes for one request, then pulses request_coef.
  task automatic applyStimulus(input bit toB, input int n, input bit withDone, input int lat);
    int ptr;
    int mask;
    int lsum;
    ptr  = toB ? ptrB : ptrA;
    mask = toB ? 32'h000F : 32'hFFFF;
    if (withDone) ptr = 0;
    lsum = 1;
    for (int i = 0; i < n; i++) begin
      int addr;
      wr_t w;
      addr   = ptr & mask;
      w.idx  = 7'(i);
      w.data = 8'((addr + 3) & 8'hFF);
      expAddrQ.push_back(16'(addr));
      expWrQ.push_back(w);
      lsum += ((i < latQ.size()) ? latQ[i] : lat) + 2;
      ptr++;
    end
    if (toB) ptrB = ptr; else ptrA = ptr;
    curLat = lat;
    useB   = toB;
    @(negedge clk);
    reqCycle   = cycleCnt + 1;
    expLatency = lsum;
    loadArmed  = 1;
    loadSeen   = 0;
    if (toB) begin
      requestCoefB = 1'b1; maxInputB = 7'(n); doneProcessingB = withDone;
    end else begin
      requestCoef = 1'b1; maxInput = 7'(n); doneProcessing = withDone;
    end
    @(negedge clk);
    requestCoef = 1'b0; doneProcessing = 1'b0;
    requestCoefB = 1'b0; doneProcessingB = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!loadSeen && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("loadSeen", 32'(loadSeen), 32'd1);
    @(negedge clk);
    checkOutput("busyAfter", 32'(selBusy), 32'd0);
    checkOutput("readsLeft", 32'(expAddrQ.size()), 32'd0);
    checkOutput("writesLeft", 32'(expWrQ.size()), 32'd0);
    expAddrQ.delete();
    expWrQ.delete();
    loadArmed = 0;
    loadSeen  = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "MemRead"}, 32'(memReadB), 32'd0);
    checkOutput({tag, "MemAddr"}, 32'(memAddrB), 32'd0);
    checkOutput({tag, "CoefWen"}, 32'(coefWenB), 32'd0);
    checkOutput({tag, "CoefWaddr"}, 32'(coefWaddrB), 32'd0);
    checkOutput({tag, "CoefWdata"}, 32'(coefWdataB), 32'd0);
    checkOutput({tag, "Loaded"}, 32'(coefLoadedB), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busyB), 32'd0);
  endtask

  initial begin
    int wrBefore;
    nRst = 1'b0;
    requestCoef = 1'b0; maxInput = '0; doneProcessing = 1'b0;
    requestCoefB = 1'b0; maxInputB = '0; doneProcessingB = 1'b0;
    memRdata = '0; memValid = 1'b0; useB = 0;
    #12;
    checkOutput("rstMemRead", 32'(memRead), 32'd0);
    checkOutput("rstMemAddr", 32'(memAddr), 32'd0);
    checkOutput("rstCoefWen", 32'(coefWen), 32'd0);
    checkOutput("rstLoaded", 32'(coefLoaded), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkResetOutputs("rstB");
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic load: 16 words, latency 2");
    applyStimulus(0, 16, 0, 2);
    waitDone(300);

    $display("[TB] multi-layer pointer");
    applyStimulus(0, 4, 0, 1);
    waitDone(300);
    applyStimulus(0, 10, 0, 1);
    waitDone(300);
    @(negedge clk);
    doneProcessing = 1'b1;
    @(negedge clk);
    doneProcessing = 1'b0;
    ptrA = 0;
    applyStimulus(0, 4, 0, 1);
    waitDone(300);

    $display("[TB] variable latency");
    latQ.push_back(1); latQ.push_back(4); latQ.push_back(8);
    applyStimulus(0, 3, 0, 1);
    waitDone(300);

    $display("[TB] zero-length request");
    applyStimulus(0, 0, 0, 1);
    waitDone(20);

    $display("[TB] request and rewind while busy");
    applyStimulus(0, 6, 0, 2);
    repeat (5) @(negedge clk);
    checkOutput("busyDuringPulse", 32'(busy), 32'd1);
    requestCoef = 1'b1; maxInput = 7'd9; doneProcessing = 1'b1;
    @(negedge clk);
    requestCoef = 1'b0; maxInput = '0; doneProcessing = 1'b0;
    waitDone(300);

    $display("[TB] request and rewind together in idle");
    applyStimulus(0, 4, 1, 1);
    waitDone(300);

    $display("[TB] address wrap on 4-bit instance");
    applyStimulus(1, 14, 0, 1);
    waitDone(300);
    applyStimulus(1, 4, 0, 1);
    waitDone(300);

    $display("[TB] reset during WAIT_DATA");
    applyStimulus(1, 4, 0, 6);
    repeat (2) @(negedge clk);
    checkOutput("busyBeforeReset", 32'(busyB), 32'd1);
    nRst = 1'b0;
    #1;
    checkResetOutputs("midRst");
    expAddrQ.delete();
    expWrQ.delete();
    loadArmed = 0;
    ptrA = 0;
    ptrB = 0;
    wrBefore = wrCount;
    @(negedge clk);
    nRst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("strayValidWrites", 32'(wrCount - wrBefore), 32'd0);
    applyStimulus(1, 2, 0, 1);
    waitDone(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
